// File: rtl/os_collector_pkg.sv
// Shared definitions for the per-lane ordered-set collector.
// Holds the PIPE symbol constants, the ordered-set type encoding, the
// collector FSM state encoding and a helper that checks a run of identifier
// symbols against one value.
package os_collector_pkg;

    localparam logic [7:0] COM    = 8'hBC;
    localparam logic [7:0] SKP    = 8'h1C;
    localparam logic [7:0] TS1_ID = 8'h4A;
    localparam logic [7:0] TS2_ID = 8'h45;

    typedef enum logic [1:0] {
        OS_NONE = 2'b00,
        OS_TS1  = 2'b01,
        OS_TS2  = 2'b10
    } osType_t;

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } colState_t;

    // True when all ten identifier symbols (set symbols 6..15) equal id.
    function automatic logic allIdEqual(input logic [79:0] ids, input logic [7:0] id);
        logic same;
        same = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (ids[8*i +: 8] != id) begin
                same = 1'b0;
            end else begin
                same = same;
            end
        end
        return same;
    endfunction

endpackage

// File: rtl/os_validator.sv
// Combinational classifier for one gathered 16-symbol ordered set.
// Ports:
//   gatheredSet : 128-bit set, symbol n in [8n+7:8n]
//   setType     : OS_TS1 / OS_TS2 when symbols 6..15 are all the TS1 / TS2
//                 identifier, OS_NONE when the set is malformed
module os_validator
    import os_collector_pkg::*;
(
    input  logic [127:0] gatheredSet,
    output osType_t      setType
);

    // COM, link/lane numbers, FTS count, rate and training control do not
    // take part in the TS1/TS2 decision.
    logic [47:0] unusedHeader;
    assign unusedHeader = gatheredSet[47:0];

    // Classify on the identifier field only.
    always_comb begin
        setType = OS_NONE;
        if (allIdEqual(gatheredSet[127:48], TS1_ID)) begin
            setType = OS_TS1;
        end else if (allIdEqual(gatheredSet[127:48], TS2_ID)) begin
            setType = OS_TS2;
        end else begin
            setType = OS_NONE;
        end
    end

endmodule

// File: rtl/os_collector.sv
// Per-lane TS1/TS2 ordered-set collector for a 4-symbol-per-clock PIPE lane.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   rxData, rxDataK   : four symbols per clock (s=0 earliest) and K flags
//   rxValid           : symbols valid this cycle
//   rxElectricalIdle  : lane in electrical idle
//   orderedSet        : last accepted TS (symbol n in [8n+7:8n])
//   validOrderedSet   : one-cycle pulse when orderedSet updates
//   osType            : 01 TS1, 10 TS2, 00 nothing accepted since reset
//   skpDetected       : one-cycle pulse on COM followed by SKP
//   errCount          : saturating count of malformed ordered sets
// LANE_ID only tags this slice of the LTSSM ordered-set bus.
module os_collector
    import os_collector_pkg::*;
#(
    parameter int LANE_ID = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  rxData,
    input  logic [3:0]   rxDataK,
    input  logic         rxValid,
    input  logic         rxElectricalIdle,
    output logic [127:0] orderedSet,
    output logic         validOrderedSet,
    output logic [1:0]   osType,
    output logic         skpDetected,
    output logic [7:0]   errCount
);

    logic [7:0] unusedLane;
    assign unusedLane = 8'(LANE_ID);

    colState_t    state, nextState;
    logic [3:0]   idx, nextIdx;
    logic [127:0] gather, nextGather;
    logic [127:0] completeSet;
    logic         completeSeen;
    logic [2:0]   kErrors;
    logic         skpSeen;
    logic [7:0]   sym;
    logic         isK;
    osType_t      setType;
    logic         setGood;
    logic         setBad;
    logic [8:0]   errSum;

    os_validator uValidator (
        .gatheredSet (completeSet),
        .setType     (setType)
    );

    // Walk the four symbols of the word in order; each symbol sees the
    // state left by the one before it. A set can complete and the next one
    // start inside the same word; 16-symbol sets allow at most one
    // completion per word, so one snapshot register is enough.
    always_comb begin
        nextState    = state;
        nextIdx      = idx;
        nextGather   = gather;
        completeSet  = 128'd0;
        completeSeen = 1'b0;
        kErrors      = 3'd0;
        skpSeen      = 1'b0;
        sym          = 8'd0;
        isK          = 1'b0;
        if (rxValid && !rxElectricalIdle) begin
            for (int s = 0; s < 4; s++) begin
                sym = rxData[8*s +: 8];
                isK = rxDataK[s];
                case (nextState)
                    HUNT: begin
                        if (isK && (sym == COM)) begin
                            nextGather[7:0] = COM;
                            nextIdx         = 4'd1;
                            nextState       = COLLECT;
                        end else begin
                            nextState = HUNT;
                        end
                    end
                    COLLECT: begin
                        if (!isK) begin
                            nextGather[{nextIdx, 3'b000} +: 8] = sym;
                            if (nextIdx == 4'd15) begin
                                completeSet  = nextGather;
                                completeSeen = 1'b1;
                                nextIdx      = 4'd0;
                                nextState    = HUNT;
                            end else begin
                                nextIdx = nextIdx + 4'd1;
                            end
                        end else if (sym == COM) begin
                            kErrors         = kErrors + 3'd1;
                            nextGather[7:0] = COM;
                            nextIdx         = 4'd1;
                        end else if ((sym == SKP) && (nextIdx == 4'd1)) begin
                            skpSeen   = 1'b1;
                            nextIdx   = 4'd0;
                            nextState = HUNT;
                        end else begin
                            kErrors   = kErrors + 3'd1;
                            nextIdx   = 4'd0;
                            nextState = HUNT;
                        end
                    end
                    default: begin
                        nextIdx   = 4'd0;
                        nextState = HUNT;
                    end
                endcase
            end
        end else begin
            // Lost symbol lock: drop any partial set silently.
            nextIdx   = 4'd0;
            nextState = HUNT;
        end
    end

    // Acceptance decision and saturating error total for this word.
    always_comb begin
        setGood = completeSeen && (setType != OS_NONE);
        setBad  = completeSeen && (setType == OS_NONE);
        errSum  = {1'b0, errCount} + {6'd0, kErrors} + {8'd0, setBad};
    end

    // State, gather buffer and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= HUNT;
            idx             <= 4'd0;
            gather          <= 128'd0;
            orderedSet      <= 128'd0;
            osType          <= 2'b00;
            validOrderedSet <= 1'b0;
            skpDetected     <= 1'b0;
            errCount        <= 8'd0;
        end else begin
            state           <= nextState;
            idx             <= nextIdx;
            gather          <= nextGather;
            validOrderedSet <= setGood;
            skpDetected     <= skpSeen;
            errCount        <= errSum[8] ? 8'd255 : errSum[7:0];
            if (setGood) begin
                orderedSet <= completeSet;
                osType     <= setType;
            end
        end
    end

endmodule

// File: tb/tb_os_collector.sv
module tb_os_collector;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  rxData;
    logic [3:0]   rxDataK;
    logic         rxValid;
    logic         rxElectricalIdle;
    logic [127:0] orderedSet;
    logic         validOrderedSet;
    logic [1:0]   osType;
    logic         skpDetected;
    logic [7:0]   errCount;

    int testsRun = 0;
    int testsFailed = 0;

    logic [8:0] symQ[$];
    int pulseCount, firstPulse, lastPulse, skpCount;

    os_collector #(.LANE_ID(3)) dut (
        .clk              (clk),
        .reset            (reset),
        .rxData           (rxData),
        .rxDataK          (rxDataK),
        .rxValid          (rxValid),
        .rxElectricalIdle (rxElectricalIdle),
        .orderedSet       (orderedSet),
        .validOrderedSet  (validOrderedSet),
        .osType           (osType),
        .skpDetected      (skpDetected),
        .errCount         (errCount)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sendWord(input logic [31:0] d, input logic [3:0] k, input logic v, input logic idle);
        @(negedge clk);
        rxData = d;
        rxDataK = k;
        rxValid = v;
        rxElectricalIdle = idle;
        @(posedge clk);
        #1;
    endtask

    task automatic pushSym(input logic k, input logic [7:0] v);
        symQ.push_back({k, v});
    endtask

    task automatic pushSet(input logic [7:0] id, input logic [7:0] base);
        pushSym(1'b1, 8'hBC);
        for (int i = 1; i < 6; i++) pushSym(1'b0, base + 8'(i));
        for (int i = 6; i < 16; i++) pushSym(1'b0, id);
    endtask

    function automatic logic [127:0] expSet(input logic [7:0] id, input logic [7:0] base);
        logic [127:0] v;
        v[7:0] = 8'hBC;
        for (int i = 1; i < 6; i++) v[8*i +: 8] = base + 8'(i);
        for (int i = 6; i < 16; i++) v[8*i +: 8] = id;
        return v;
    endfunction

    // Sends the queued symbols as valid words, tallying output pulses.
    task automatic runStream();
        logic [31:0] d;
        logic [3:0]  k;
        logic [8:0]  e;
        int nWords;
        while ((symQ.size() % 4) != 0) pushSym(1'b0, 8'h00);
        nWords = symQ.size() / 4;
        pulseCount = 0; firstPulse = -1; lastPulse = -1; skpCount = 0;
        for (int w = 0; w < nWords; w++) begin
            for (int s = 0; s < 4; s++) begin
                e = symQ[w*4 + s];
                d[8*s +: 8] = e[7:0];
                k[s] = e[8];
            end
            sendWord(d, k, 1'b1, 1'b0);
            if (validOrderedSet) begin
                pulseCount++;
                if (firstPulse < 0) firstPulse = w;
                lastPulse = w;
            end
            if (skpDetected) skpCount++;
        end
        symQ.delete();
    endtask

    task automatic pulseReset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        rxData = 32'd0;
        rxDataK = 4'd0;
        rxValid = 1'b0;
        rxElectricalIdle = 1'b0;
        pulseReset();

        checkVal("rst_orderedSet", orderedSet, 128'd0);
        checkVal("rst_osType", 128'(osType), 128'd0);
        checkVal("rst_valid", 128'(validOrderedSet), 128'd0);
        checkVal("rst_skp", 128'(skpDetected), 128'd0);
        checkVal("rst_errCount", 128'(errCount), 128'd0);

        // Aligned TS1: COM at s=0, four words.
        pushSet(8'h4A, 8'h00);
        runStream();
        checkVal("ts1_pulses", 128'(pulseCount), 128'd1);
        checkVal("ts1_pulse_word", 128'(firstPulse), 128'd3);
        checkVal("ts1_osType", 128'(osType), 128'd1);
        checkVal("ts1_sym0", 128'(orderedSet[7:0]), 128'hBC);
        checkVal("ts1_sym15", 128'(orderedSet[127:120]), 128'h4A);
        checkVal("ts1_set", orderedSet, expSet(8'h4A, 8'h00));
        sendWord(32'd0, 4'd0, 1'b0, 1'b0);
        checkVal("ts1_pulse_width", 128'(validOrderedSet), 128'd0);
        checkVal("ts1_hold", orderedSet, expSet(8'h4A, 8'h00));

        // COM at s=2, two back-to-back TS2; second completes mid-stream.
        pushSym(1'b0, 8'h00);
        pushSym(1'b0, 8'h00);
        pushSet(8'h45, 8'h10);
        pushSet(8'h45, 8'h20);
        runStream();
        checkVal("ts2_pulses", 128'(pulseCount), 128'd2);
        checkVal("ts2_first_word", 128'(firstPulse), 128'd4);
        checkVal("ts2_spacing", 128'(lastPulse - firstPulse), 128'd4);
        checkVal("ts2_osType", 128'(osType), 128'd2);
        checkVal("ts2_set", orderedSet, expSet(8'h45, 8'h20));
        checkVal("ts2_errCount", 128'(errCount), 128'd0);

        // COM followed by SKP.
        pushSym(1'b1, 8'hBC);
        pushSym(1'b1, 8'h1C);
        runStream();
        checkVal("skp_pulse", 128'(skpCount), 128'd1);
        checkVal("skp_no_valid", 128'(pulseCount), 128'd0);
        checkVal("skp_errCount", 128'(errCount), 128'd0);

        // Malformed TS: symbol 9 = 4B.
        pushSet(8'h4A, 8'h00);
        symQ[9] = {1'b0, 8'h4B};
        runStream();
        checkVal("bad_no_pulse", 128'(pulseCount), 128'd0);
        checkVal("bad_errCount", 128'(errCount), 128'd1);
        checkVal("bad_set_kept", orderedSet, expSet(8'h45, 8'h20));
        checkVal("bad_osType_kept", 128'(osType), 128'd2);

        // Three errors in one word: COM restart twice, then a stray K.
        pushSym(1'b1, 8'hBC);
        pushSym(1'b1, 8'hBC);
        pushSym(1'b1, 8'hBC);
        pushSym(1'b1, 8'h7C);
        runStream();
        checkVal("multi_err", 128'(errCount), 128'd4);

        // 299 more malformed sets (300 in total) saturate the counter.
        for (int r = 0; r < 299; r++) begin
            pushSet(8'h4A, 8'h00);
            symQ[9] = {1'b0, 8'h4B};
            runStream();
        end
        checkVal("err_saturate", 128'(errCount), 128'd255);

        pulseReset();
        checkVal("rst2_errCount", 128'(errCount), 128'd0);
        checkVal("rst2_orderedSet", orderedSet, 128'd0);

        // Electrical idle after 8 symbols, then a full TS1.
        pushSet(8'h4A, 8'h30);
        while (symQ.size() > 8) void'(symQ.pop_back());
        runStream();
        sendWord(32'h4A4A4A4A, 4'd0, 1'b1, 1'b1);
        pushSet(8'h4A, 8'h40);
        runStream();
        checkVal("eidle_pulses", 128'(pulseCount), 128'd1);
        checkVal("eidle_errCount", 128'(errCount), 128'd0);
        checkVal("eidle_set", orderedSet, expSet(8'h4A, 8'h40));

        // Reset at idx=10, then a full TS1.
        pushSym(1'b0, 8'h00);
        pushSym(1'b0, 8'h00);
        pushSet(8'h45, 8'h50);
        while (symQ.size() > 12) void'(symQ.pop_back());
        runStream();
        @(negedge clk);
        reset = 1'b1;
        #2;
        checkVal("midrst_orderedSet", orderedSet, 128'd0);
        checkVal("midrst_osType", 128'(osType), 128'd0);
        checkVal("midrst_valid", 128'(validOrderedSet), 128'd0);
        checkVal("midrst_skp", 128'(skpDetected), 128'd0);
        checkVal("midrst_errCount", 128'(errCount), 128'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        pushSet(8'h4A, 8'h60);
        runStream();
        checkVal("postrst_pulses", 128'(pulseCount), 128'd1);
        checkVal("postrst_set", orderedSet, expSet(8'h4A, 8'h60));
        checkVal("postrst_errCount", 128'(errCount), 128'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
